i2c_master_ctrl: RTL and testbench

Single-master I2C controller (initiator) that drives the bus our I2C LED target responds on. It executes one bus primitive per command (START / repeated START, WRITE byte, READ byte, STOP), generates SCL with target clock-stretch support, and reports ACK/NACK and read data through a one-cycle response strobe. It sits between a host-side sequencer and the open-drain pad logic, using the same released-high `scl_o`/`sda_o` convention as our target.

---
 rtl/i2c_master_ctrl.sv | 173 +++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: one bus primitive (START, WRITE, READ, STOP) per command,
// quarter-period SCL generation with clock-stretch wait, one-cycle response strobe.
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    input  logic       cmd_last,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o
);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_START, S_STOP, S_BIT, S_RESP} state_t;
    typedef enum logic [1:0] {C_START, C_WRITE, C_READ, C_STOP} cmd_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_q;
    logic [3:0]    r_bit;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic          r_read;
    logic          r_last;
    logic          r_ack;
    logic          r_scl;
    logic          r_sda;
    logic          r_cmd_ready;
    logic          r_rsp_valid;
    logic [7:0]    r_rsp_data;
    logic          r_rsp_nack;
    logic          r_busy;

    logic w_accept;
    logic w_frozen;
    logic w_qend;

    assign w_accept = cmd_valid & r_cmd_ready;
    assign w_frozen = (r_q == 2'd1) && !scl_i;
    assign w_qend   = !w_frozen && (r_cnt == LAST);

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_nack  = r_rsp_nack;
    assign busy      = r_busy;
    assign scl_o     = r_scl;
    assign sda_o     = r_sda;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_q         <= '0;
            r_bit       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_read      <= 1'b0;
            r_last      <= 1'b0;
            r_ack       <= 1'b0;
            r_scl       <= 1'b1;
            r_sda       <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_nack  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_HOLD, S_RESP: begin
                    r_cmd_ready <= 1'b1;
                    if (r_state == S_RESP)
                        r_state <= r_busy ? S_HOLD : S_IDLE;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_cnt       <= '0;
                        r_q         <= '0;
                        r_bit       <= '0;
                        if (cmd == C_START) begin
                            r_state <= S_START;
                            r_scl   <= 1'b1;
                            r_sda   <= 1'b1;
                        end else if (!r_busy) begin
                            // Bus not owned: answer NACK at once without touching the lines
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_nack  <= 1'b1;
                            r_cmd_ready <= 1'b1;
                        end else if (cmd == C_STOP) begin
                            r_state <= S_STOP;
                            r_scl   <= 1'b0;
                            r_sda   <= 1'b0;
                        end else begin
                            r_state <= S_BIT;
                            r_read  <= (cmd == C_READ);
                            r_last  <= cmd_last;
                            r_tx    <= cmd_data;
                            r_scl   <= 1'b0;
                            r_sda   <= (cmd == C_READ) | cmd_data[7];
                        end
                    end
                end
                default: begin
                    if (!w_frozen) begin
                        r_cnt <= w_qend ? '0 : r_cnt + CW'(1);
                        if (w_qend) begin
                            r_q <= r_q + 2'd1;
                            case (r_state)
                                S_START: begin
                                    if (r_q == 2'd1) r_sda <= 1'b0;
                                    if (r_q == 2'd2) r_scl <= 1'b0;
                                    if (r_q == 2'd3) begin
                                        r_busy      <= 1'b1;
                                        r_state     <= S_RESP;
                                        r_rsp_valid <= 1'b1;
                                        r_rsp_nack  <= 1'b0;
                                        r_cmd_ready <= 1'b1;
                                    end
                                end
                                S_STOP: begin
                                    if (r_q == 2'd0) r_scl <= 1'b1;
                                    if (r_q == 2'd1) r_sda <= 1'b1;
                                    if (r_q == 2'd3) begin
                                        r_busy      <= 1'b0;
                                        r_state     <= S_RESP;
                                        r_rsp_valid <= 1'b1;
                                        r_rsp_nack  <= 1'b0;
                                        r_cmd_ready <= 1'b1;
                                    end
                                end
                                default: begin
                                    if (r_q == 2'd0) r_scl <= 1'b1;
                                    if (r_q == 2'd2) begin
                                        r_scl <= 1'b0;
                                        if (r_bit == 4'd8) r_ack <= sda_i;
                                        else               r_rx  <= {r_rx[6:0], sda_i};
                                    end
                                    if (r_q == 2'd3) begin
                                        if (r_bit == 4'd8) begin
                                            r_state     <= S_RESP;
                                            r_rsp_valid <= 1'b1;
                                            r_rsp_nack  <= r_read ? 1'b0 : r_ack;
                                            r_cmd_ready <= 1'b1;
                                            if (r_read) r_rsp_data <= r_rx;
                                        end else begin
                                            // Ninth bit carries the master ACK/NACK on reads, release on writes
                                            r_bit <= r_bit + 4'd1;
                                            if (r_bit == 4'd7) r_sda <= r_read ? r_last : 1'b1;
                                            else               r_sda <= r_read | r_tx[6];
                                            r_tx <= {r_tx[6:0], 1'b0};
                                        end
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl with a small LED-target bus model at 7'h4A.
module tb_i2c_master_ctrl;
    localparam int unsigned K = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_last = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_i, sda_i, scl_o, sda_o;
    logic [7:0] rsp_data;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(K)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_data(cmd_data), .cmd_last(cmd_last),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack), .busy(busy),
        .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o)
    );

    typedef struct {
        string      name;
        logic       nack;
        logic [7:0] data;
        bit         chk_data;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Bus model state
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic [3:0] m_idx = 4'd0;
    logic [1:0] m_mode = 2'b00;
    logic       m_first = 1'b0, m_ack = 1'b1;
    logic [7:0] m_rd = 8'h00;
    int         m_stretch = 0;
    logic [8:0] bus_bits = 9'h000;
    int         hcnt = 0, last_high = 0, start_cnt = 0, lowc = 0;
    logic [7:0] slave_rd_byte = 8'h00;
    int         stretch_req = 0;
    logic       slv_sda, w_stretch;

    assign w_stretch = (m_mode == 2'b01) && (m_idx == 4'd4) && (m_stretch != 0);
    assign scl_i     = scl_o & ~w_stretch;
    assign slv_sda   = (m_mode == 2'b10 && m_idx < 4'd8) ? m_rd[3'(4'd7 - m_idx)] :
                       (m_mode == 2'b01 && m_idx == 4'd8) ? ~m_ack : 1'b1;
    assign sda_i     = sda_o & slv_sda;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        prev_scl <= scl_o;
        prev_sda <= sda_o;
        if (!scl_o || !sda_o) lowc <= lowc + 1;
        if (prev_scl && scl_o && prev_sda && !sda_o) start_cnt <= start_cnt + 1;
        if (scl_o) hcnt <= hcnt + 1;
        else if (prev_scl) begin
            last_high <= hcnt;
            hcnt <= 0;
        end
        if (reset) begin
            m_mode <= 2'b00;
            m_stretch <= 0;
        end else if (cmd_valid && cmd_ready) begin
            m_idx     <= 4'd0;
            bus_bits  <= 9'h000;
            m_mode    <= cmd;
            m_stretch <= stretch_req;
            if (cmd == 2'b00) m_first <= 1'b1;
            if (cmd == 2'b01) begin
                m_ack   <= m_first ? (cmd_data[7:1] == 7'h4A) : 1'b1;
                m_first <= 1'b0;
            end
            if (cmd == 2'b10) m_rd <= slave_rd_byte;
        end else begin
            if (prev_scl && !scl_o) m_idx <= m_idx + 4'd1;
            if (!prev_scl && scl_o) bus_bits <= {bus_bits[7:0], sda_i};
            if (scl_o && w_stretch) m_stretch <= m_stretch - 1;
        end
    end

    task automatic chk(input string nm, input int act, input int xp);
        total++;
        if (act != xp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, xp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_nack"}, int'(rsp_nack), int'(mon_e.nack));
                if (mon_e.chk_data) chk({mon_e.name, "_data"}, int'(rsp_data), int'(mon_e.data));
                chk({mon_e.name, "_latency"}, cyc - mon_e.acc, mon_e.lat);
            end
        end
    end

    // Called at a negedge; waits for ready, offers one command, optionally waits for its response.
    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic last,
                         input logic [7:0] srd, input int strq, input bit push,
                         input logic enack, input logic [7:0] edata, input bit cd,
                         input int elat, input string nm);
        int n;
        exp_t e;
        n = 0;
        slave_rd_byte = srd;
        stretch_req   = strq;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_data  = d;
        cmd_last  = last;
        if (push) begin
            e.name = nm; e.nack = enack; e.data = edata; e.chk_data = cd; e.lat = elat; e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        stretch_req = 0;
        if (elat > 1) chk({nm, "_ready_drop"}, int'(cmd_ready), 0);
        if (push) begin
            n = 0;
            while (sb.size() != 0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk({nm, "_done"}, sb.size(), 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc0, sc0, n;
        repeat (4) @(negedge clk);
        chk("rst_scl", int'(scl_o), 1);
        chk("rst_sda", int'(sda_o), 1);
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_nack", int'(rsp_nack), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(cmd_ready), 1);

        // Addressed write to the LED target
        issue(2'b00, 8'h00, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 17, "start1");
        chk("busy_after_start", int'(busy), 1);
        issue(2'b01, 8'h94, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 145, "wr94");
        chk("wr94_bus", int'(bus_bits), 9'h128);
        chk("scl_high_time", last_high, 8);
        issue(2'b01, 8'h3C, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 145, "wr3c");
        chk("wr3c_bus", int'(bus_bits), 9'h078);
        issue(2'b11, 8'h00, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 17, "stop1");
        chk("busy_after_stop", int'(busy), 0);

        // Absent address
        issue(2'b00, 8'h00, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 17, "start2");
        issue(2'b01, 8'h96, 1'b0, 8'h00, 0, 1, 1'b1, 8'h00, 0, 145, "wr96");
        chk("wr96_bus", int'(bus_bits), 9'h12D);
        issue(2'b11, 8'h00, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 17, "stop2");
        @(negedge clk);
        chk("idle_scl", int'(scl_o), 1);
        chk("idle_sda", int'(sda_o), 1);
        chk("idle_busy", int'(busy), 0);

        // Commands while the bus is not owned
        lc0 = lowc;
        issue(2'b01, 8'h11, 1'b0, 8'h00, 0, 1, 1'b1, 8'h00, 0, 1, "ill_wr");
        issue(2'b11, 8'h00, 1'b0, 8'h00, 0, 1, 1'b1, 8'h00, 0, 1, "ill_stop");
        repeat (3) @(negedge clk);
        chk("ill_no_low", lowc - lc0, 0);

        // Reads: NACK then ACK in the ninth bit
        issue(2'b00, 8'h00, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 17, "start3");
        issue(2'b01, 8'h95, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 145, "wr95");
        issue(2'b10, 8'h00, 1'b1, 8'hA5, 0, 1, 1'b0, 8'hA5, 1, 145, "rd_a5");
        chk("rd_a5_bus", int'(bus_bits), 9'h14B);
        issue(2'b10, 8'h00, 1'b0, 8'h3C, 0, 1, 1'b0, 8'h3C, 1, 145, "rd_3c");
        chk("rd_3c_bus", int'(bus_bits), 9'h078);
        issue(2'b11, 8'h00, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 17, "stop3");
        chk("rsp_data_hold", int'(rsp_data), 8'h3C);

        // Clock stretch, then repeated START
        issue(2'b00, 8'h00, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 17, "start4");
        issue(2'b01, 8'h94, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 145, "wr94b");
        issue(2'b01, 8'h5A, 1'b0, 8'h00, 10, 1, 1'b0, 8'h00, 0, 155, "wr5a_stretch");
        chk("wr5a_bus", int'(bus_bits), 9'h0B4);
        sc0 = start_cnt;
        issue(2'b00, 8'h00, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 17, "rstart");
        chk("rstart_sda_fall", start_cnt - sc0, 1);
        chk("rstart_busy", int'(busy), 1);
        issue(2'b11, 8'h00, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 17, "stop4");

        // Reset in the middle of a write
        issue(2'b00, 8'h00, 1'b0, 8'h00, 0, 1, 1'b0, 8'h00, 0, 17, "start5");
        issue(2'b01, 8'hC3, 1'b0, 8'h00, 0, 0, 1'b0, 8'h00, 0, 145, "wr_c3");
        n = 0;
        while (m_idx != 4'd2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach_bit", int'(m_idx), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_scl", int'(scl_o), 1);
        chk("mid_sda", int'(sda_o), 1);
        chk("mid_busy", int'(busy), 0);
        chk("mid_rsp_valid", int'(rsp_valid), 0);
        chk("mid_ready_low", int'(cmd_ready), 0);
        @(negedge clk);
        chk("mid_ready_high", int'(cmd_ready), 1);
        repeat (200) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
